output_arbiter: RTL



---
 rtl/router_pkg.sv | 25 ++
 rtl/output_arbiter_rr.sv | 49 ++++
 rtl/output_arbiter.sv | 67 ++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared router constants: direction label bits and requester indices.
package router_pkg;

  localparam int unsigned LABEL_W   = 5;

  localparam int unsigned DIR_L     = 0;
  localparam int unsigned DIR_W     = 1;
  localparam int unsigned DIR_N     = 2;
  localparam int unsigned DIR_E     = 3;
  localparam int unsigned DIR_S     = 4;

  localparam int unsigned REQ_L     = 0;
  localparam int unsigned REQ_WU    = 1;
  localparam int unsigned REQ_NU    = 2;
  localparam int unsigned REQ_E     = 3;
  localparam int unsigned REQ_S     = 4;
  localparam int unsigned REQ_WM1   = 5;
  localparam int unsigned REQ_WM2   = 6;
  localparam int unsigned REQ_WM3   = 7;
  localparam int unsigned REQ_NM1   = 8;
  localparam int unsigned REQ_NM2   = 9;
  localparam int unsigned REQ_NM3   = 10;
  localparam int unsigned N_REQ_DEF = 11;

endpackage

// File: rtl/output_arbiter_rr.sv
// N-input round-robin arbiter: one-hot combinational grant, pointer advances past the winner.
module rr_arbiter #(
  parameter int unsigned N     = 11,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     i_req,
  input  logic             i_en,
  output logic [N-1:0]     o_grant_c,
  output logic [IDX_W-1:0] o_idx_c,
  output logic             o_valid_c
);

  logic [IDX_W-1:0] r_ptr;
  logic [N-1:0]     w_grant;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;

  // First set request at or after r_ptr, wrapping at N-1.
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      int unsigned k;
      k = 32'(r_ptr) + j;
      if (k >= N) k = k - N;
      if (!w_found && i_req[IDX_W'(k)]) begin
        w_found             = 1'b1;
        w_grant[IDX_W'(k)] = 1'b1;
        w_idx               = IDX_W'(k);
      end
    end
  end

  assign o_grant_c = i_en ? w_grant : '0;
  assign o_idx_c   = w_idx;
  assign o_valid_c = i_en & w_found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_en && w_found) begin
      r_ptr <= (w_idx == IDX_W'(N - 1)) ? '0 : w_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/output_arbiter.sv
// Output-port switch allocation: extracts this port's requests, arbitrates, registers the winning flit.
module output_arbiter
  import router_pkg::*;
#(
  parameter int unsigned DATASIZE = 30,
  parameter int unsigned N_REQ    = N_REQ_DEF,
  parameter int unsigned PORT_IDX = DIR_L
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ*DATASIZE-1:0]   req_data,
  input  logic [N_REQ*LABEL_W-1:0]    req_label,
  input  logic                        full_in,
  output logic [N_REQ-1:0]            grant,
  output logic [DATASIZE-1:0]         data_out,
  output logic                        valid_out
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]    w_req;
  logic [DATASIZE-1:0] w_data [N_REQ];
  logic [IDX_W-1:0]    w_idx;
  logic                w_win;
  logic                w_en;
  logic                w_unused_label;
  logic                r_valid;
  logic [DATASIZE-1:0] r_data;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign w_req[i]  = req_label[i*LABEL_W + PORT_IDX];
    assign w_data[i] = req_data[i*DATASIZE +: DATASIZE];
  end

  // Label bits for other ports belong to sibling instances.
  assign w_unused_label = ^req_label;

  // Blocked downstream or in reset: no grant, pointer frozen.
  assign w_en = rst_n & ~full_in;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (w_req),
    .i_en      (w_en),
    .o_grant_c (grant),
    .o_idx_c   (w_idx),
    .o_valid_c (w_win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= w_win;
      if (w_win) r_data <= w_data[w_idx];
    end
  end

  assign valid_out = r_valid;
  assign data_out  = r_data;

endmodule
